sync_wait_split: RTL and testbench

//  Clocked fork stage: the counterpart of the wait-merge join in the async_ctrl library.

---
 rtl/async_ctrl_pkg.sv | 22 ++
 rtl/sync_wait_split_if.sv | 31 +++
 rtl/split_free_tracker.sv | 43 ++++
 rtl/sync_wait_split.sv | 148 ++++++++++++++
 tb/tb_sync_wait_split.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/async_ctrl_pkg.sv
// async_ctrl_pkg
//   Shared types and helpers for the clocked async_ctrl stages.
//   - split_state_t : FSM states of the fork stage (IDLE, WAIT)
//   - SPLIT_MAX_OUT : upper limit on the number of fork outputs
//   - split_cnt_w   : watchdog counter width for a given cycle limit
package async_ctrl_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } split_state_t;

  localparam int SPLIT_MAX_OUT = 16;

  // clog2-based width, never narrower than one bit
  function automatic int split_cnt_w(input int limit);
    int w;
    w = $clog2(limit);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_wait_split_if.sv
// sync_wait_split_if
//   Handshake bundle of the fork stage.
//   Upstream side : i_drive, i_data  -> o_free
//   Downstream    : o_driveNext, o_data -> i_freeNext
//   Status        : o_busy, o_overrun, o_timeout
//   modport slave  : the fork stage itself
//   modport master : the environment driving the fork stage
interface sync_wait_split_if #(
  parameter int NUM_OUT = 4,
  parameter int DATA_W  = 8
);
  logic                      i_drive;
  logic [NUM_OUT*DATA_W-1:0] i_data;
  logic                      o_free;
  logic [NUM_OUT-1:0]        o_driveNext;
  logic [NUM_OUT*DATA_W-1:0] o_data;
  logic [NUM_OUT-1:0]        i_freeNext;
  logic                      o_busy;
  logic                      o_overrun;
  logic                      o_timeout;

  modport slave (
    input  i_drive, i_data, i_freeNext,
    output o_free, o_driveNext, o_data, o_busy, o_overrun, o_timeout
  );

  modport master (
    output i_drive, i_data, i_freeNext,
    input  o_free, o_driveNext, o_data, o_busy, o_overrun, o_timeout
  );
endinterface

// File: rtl/split_free_tracker.sv
// split_free_tracker
//   Holds the mask of channels whose free is still outstanding.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : set every channel pending (new transaction issued)
//   clr_en    : frees are honoured only while this is high (FSM in WAIT)
//   free_next : per-channel free pulses
//   all_clear : no channel would remain pending after this cycle's frees
module split_free_tracker #(
  parameter int NUM_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clr_en,
  input  logic [NUM_OUT-1:0] free_next,
  output logic               all_clear
);

  logic [NUM_OUT-1:0] pending_r;
  logic [NUM_OUT-1:0] remain_s;

  // Channels still outstanding once this cycle's frees are applied;
  // a repeated free on a cleared channel has nothing left to clear.
  always_comb begin
    remain_s = pending_r & ~free_next;
  end

  // Pending mask register: load wins over clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {NUM_OUT{1'b0}};
    end else if (load) begin
      pending_r <= {NUM_OUT{1'b1}};
    end else if (clr_en) begin
      pending_r <= remain_s;
    end else begin
      pending_r <= pending_r;
    end
  end

  assign all_clear = (remain_s == {NUM_OUT{1'b0}});

endmodule

// File: rtl/sync_wait_split.sv
// sync_wait_split
//   Clocked fork stage: one upstream drive is registered and fanned out as
//   a drive pulse to every consumer; a single upstream free is returned once
//   every consumer has freed.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : sync_wait_split_if.slave (drive/data in, per-channel drive/data
//         out, per-channel free in, free out, busy/overrun/timeout status)
//   Optional feature: define SPLIT_TIMEOUT_EN to build the WAIT watchdog
//   (sticky o_timeout after TIMEOUT_CYCLES-1 WAIT cycles); otherwise
//   o_timeout is tied low.
module sync_wait_split
  import async_ctrl_pkg::*;
#(
  parameter int NUM_OUT        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  sync_wait_split_if.slave   bus
);

  if (NUM_OUT < 2 || NUM_OUT > SPLIT_MAX_OUT || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("sync_wait_split: parameter out of range");
  end

  split_state_t              state_r;
  split_state_t              next_state_s;
  logic                      load_s;
  logic                      release_s;
  logic                      all_clear_s;
  logic [NUM_OUT*DATA_W-1:0] data_r;
  logic [NUM_OUT-1:0]        drive_next_r;
  logic                      free_r;
  logic                      busy_r;
  logic                      overrun_r;

  split_free_tracker #(.NUM_OUT(NUM_OUT)) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .clr_en    (state_r == WAIT),
    .free_next (bus.i_freeNext),
    .all_clear (all_clear_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: accept a drive in IDLE, release once all channels freed
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    release_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.i_drive) begin
          load_s       = 1'b1;
          next_state_s = WAIT;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT: begin
        if (all_clear_s) begin
          release_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Data register, handshake pulses and sticky overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r       <= {(NUM_OUT*DATA_W){1'b0}};
      drive_next_r <= {NUM_OUT{1'b0}};
      free_r       <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      if (load_s) begin
        data_r <= bus.i_data;
      end else begin
        data_r <= data_r;
      end
      drive_next_r <= load_s ? {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};
      free_r       <= release_s;
      busy_r       <= (next_state_s == WAIT);
      // a drive while a transaction is outstanding is dropped but remembered
      overrun_r    <= overrun_r | ((state_r == WAIT) & bus.i_drive);
    end
  end

  assign bus.o_data      = data_r;
  assign bus.o_driveNext = drive_next_r;
  assign bus.o_free      = free_r;
  assign bus.o_busy      = busy_r;
  assign bus.o_overrun   = overrun_r;

`ifdef SPLIT_TIMEOUT_EN
  localparam int               CNT_W    = split_cnt_w(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PREV = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] wd_cnt_r;
  logic             timeout_r;

  // Watchdog: counts WAIT cycles, saturates, flags when the limit is reached
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r  <= {CNT_W{1'b0}};
      timeout_r <= 1'b0;
    end else if (load_s) begin
      wd_cnt_r  <= {CNT_W{1'b0}};
      timeout_r <= timeout_r;
    end else if (state_r == WAIT) begin
      if (wd_cnt_r != CNT_LAST) begin
        wd_cnt_r <= wd_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      // flag raised on the same edge the counter reaches its last value
      timeout_r <= timeout_r | (wd_cnt_r == CNT_PREV);
    end else begin
      wd_cnt_r  <= wd_cnt_r;
      timeout_r <= timeout_r;
    end
  end

  assign bus.o_timeout = timeout_r;
`else
  assign bus.o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sync_wait_split.sv
module tb_sync_wait_split;

  localparam int NUM_OUT = 4;
  localparam int DATA_W  = 8;
`ifdef SPLIT_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  sync_wait_split_if #(.NUM_OUT(NUM_OUT), .DATA_W(DATA_W)) bus ();

  sync_wait_split #(
    .NUM_OUT        (NUM_OUT),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit: simulation still running at %0t, required finish", $time);
    $fatal(1, "time limit");
  end

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_drive = 1'b0;
    bus.i_data = 32'h0;
    bus.i_freeNext = 4'h0;
    step();
    step();
    total_cnt++;
    if ({bus.o_free, bus.o_driveNext, bus.o_busy, bus.o_overrun, bus.o_timeout} !== 8'h00)
      $display("FAIL reset_flags: got %b required 0", {bus.o_free, bus.o_driveNext, bus.o_busy, bus.o_overrun, bus.o_timeout});
    else pass_cnt++;
    total_cnt++;
    if (bus.o_data !== 32'h0) $display("FAIL reset_data: got %h required 0", bus.o_data);
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    bus.i_drive = 1'b1;
    bus.i_data = 32'hDDCCBBAA;
    step();
    bus.i_drive = 1'b0;
    total_cnt++;
    if (bus.o_driveNext !== 4'hF) $display("FAIL basic_drive: got %h required f", bus.o_driveNext);
    else pass_cnt++;
    total_cnt++;
    if (bus.o_data[7:0] !== 8'hAA || bus.o_data[31:24] !== 8'hDD)
      $display("FAIL basic_data: got %h required ddccbbaa", bus.o_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.o_busy !== 1'b1) $display("FAIL basic_busy: got %b required 1", bus.o_busy);
    else pass_cnt++;
    bus.i_freeNext = 4'h1;
    step();
    total_cnt++;
    if (bus.o_driveNext !== 4'h0) $display("FAIL basic_drive_pulse: got %h required 0", bus.o_driveNext);
    else pass_cnt++;
    bus.i_freeNext = 4'h2;
    step();
    bus.i_freeNext = 4'h4;
    step();
    total_cnt++;
    if (bus.o_free !== 1'b0) $display("FAIL basic_free_early: got %b required 0", bus.o_free);
    else pass_cnt++;
    bus.i_freeNext = 4'h8;
    step();
    total_cnt++;
    if (bus.o_free !== 1'b1 || bus.o_busy !== 1'b0)
      $display("FAIL basic_free: got free=%b busy=%b required free=1 busy=0", bus.o_free, bus.o_busy);
    else pass_cnt++;
    bus.i_freeNext = 4'h0;
    step();
    total_cnt++;
    if (bus.o_free !== 1'b0) $display("FAIL basic_free_pulse: got %b required 0", bus.o_free);
    else pass_cnt++;
  endtask

  task automatic test_frees_together();
    bus.i_drive = 1'b1;
    bus.i_data = 32'h04030201;
    step();
    bus.i_drive = 1'b0;
    total_cnt++;
    if (bus.o_driveNext !== 4'hF || bus.o_data !== 32'h04030201)
      $display("FAIL together_drive: got drive=%h data=%h required f 04030201", bus.o_driveNext, bus.o_data);
    else pass_cnt++;
    bus.i_freeNext = 4'hF;
    step();
    bus.i_freeNext = 4'h0;
    total_cnt++;
    if (bus.o_free !== 1'b1 || bus.o_busy !== 1'b0)
      $display("FAIL together_free: got free=%b busy=%b required free=1 busy=0", bus.o_free, bus.o_busy);
    else pass_cnt++;
    // back-to-back: drive accepted in the cycle o_free is high
    bus.i_drive = 1'b1;
    bus.i_data = 32'hA5A5A5A5;
    step();
    bus.i_drive = 1'b0;
    total_cnt++;
    if (bus.o_driveNext !== 4'hF || bus.o_data !== 32'hA5A5A5A5 || bus.o_overrun !== 1'b0)
      $display("FAIL back_to_back: got drive=%h data=%h ovr=%b required f a5a5a5a5 0", bus.o_driveNext, bus.o_data, bus.o_overrun);
    else pass_cnt++;
    bus.i_freeNext = 4'hF;
    step();
    bus.i_freeNext = 4'h0;
    step();
  endtask

  task automatic test_stray_dup_frees();
    int frees;
    frees = 0;
    bus.i_freeNext = 4'h1;
    step();
    bus.i_freeNext = 4'h0;
    total_cnt++;
    if (bus.o_busy !== 1'b0 || bus.o_free !== 1'b0 || bus.o_driveNext !== 4'h0)
      $display("FAIL stray_free: got busy=%b free=%b drive=%h required 0 0 0", bus.o_busy, bus.o_free, bus.o_driveNext);
    else pass_cnt++;
    bus.i_drive = 1'b1;
    bus.i_data = 32'h0BADF00D;
    step();
    bus.i_drive = 1'b0;
    bus.i_freeNext = 4'h1;
    step();
    frees += int'(bus.o_free);
    step();
    frees += int'(bus.o_free);
    bus.i_freeNext = 4'hE;
    step();
    frees += int'(bus.o_free);
    bus.i_freeNext = 4'h0;
    step();
    frees += int'(bus.o_free);
    step();
    frees += int'(bus.o_free);
    total_cnt++;
    if (frees !== 1) $display("FAIL dup_free_count: got %0d required 1", frees);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    bus.i_drive = 1'b1;
    bus.i_data = 32'hCAFEF00D;
    step();
    bus.i_data = 32'h11111111;
    step();
    bus.i_drive = 1'b0;
    total_cnt++;
    if (bus.o_data !== 32'hCAFEF00D || bus.o_overrun !== 1'b1 || bus.o_driveNext !== 4'h0)
      $display("FAIL overrun_set: got data=%h ovr=%b drive=%h required cafef00d 1 0", bus.o_data, bus.o_overrun, bus.o_driveNext);
    else pass_cnt++;
    bus.i_freeNext = 4'hF;
    step();
    bus.i_freeNext = 4'h0;
    total_cnt++;
    if (bus.o_free !== 1'b1) $display("FAIL overrun_free: got %b required 1", bus.o_free);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.o_overrun !== 1'b1 || bus.o_data !== 32'hCAFEF00D)
      $display("FAIL overrun_sticky: got ovr=%b data=%h required 1 cafef00d", bus.o_overrun, bus.o_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    int frees;
    frees = 0;
    bus.i_drive = 1'b1;
    bus.i_data = 32'h55AA55AA;
    step();
    bus.i_drive = 1'b0;
    bus.i_freeNext = 4'h1;
    step();
    bus.i_freeNext = 4'h0;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.o_free, bus.o_driveNext, bus.o_busy, bus.o_overrun, bus.o_timeout} !== 8'h00 || bus.o_data !== 32'h0)
      $display("FAIL reset_async: got flags=%b data=%h required 0 0",
               {bus.o_free, bus.o_driveNext, bus.o_busy, bus.o_overrun, bus.o_timeout}, bus.o_data);
    else pass_cnt++;
    step();
    rst = 1'b0;
    bus.i_freeNext = 4'hE;
    step();
    frees += int'(bus.o_free);
    bus.i_freeNext = 4'h0;
    step();
    frees += int'(bus.o_free);
    total_cnt++;
    if (frees !== 0 || bus.o_busy !== 1'b0) $display("FAIL reset_no_free: got frees=%0d busy=%b required 0 0", frees, bus.o_busy);
    else pass_cnt++;
    bus.i_drive = 1'b1;
    bus.i_data = 32'h0F1E2D3C;
    step();
    bus.i_drive = 1'b0;
    total_cnt++;
    if (bus.o_driveNext !== 4'hF || bus.o_data !== 32'h0F1E2D3C)
      $display("FAIL reset_recover_drive: got drive=%h data=%h required f 0f1e2d3c", bus.o_driveNext, bus.o_data);
    else pass_cnt++;
    bus.i_freeNext = 4'hF;
    step();
    bus.i_freeNext = 4'h0;
    total_cnt++;
    if (bus.o_free !== 1'b1) $display("FAIL reset_recover_free: got %b required 1", bus.o_free);
    else pass_cnt++;
    step();
  endtask

  task automatic test_watchdog();
    bus.i_drive = 1'b1;
    bus.i_data = 32'h89ABCDEF;
    step();
    bus.i_drive = 1'b0;
    bus.i_freeNext = 4'hB;
    step();
    bus.i_freeNext = 4'h0;
    for (int i = 0; i < 13; i++) step();
    total_cnt++;
    if (bus.o_timeout !== 1'b0 || bus.o_busy !== 1'b1 || bus.o_free !== 1'b0)
      $display("FAIL wd_before: got to=%b busy=%b free=%b required 0 1 0", bus.o_timeout, bus.o_busy, bus.o_free);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.o_timeout !== TO_EN || bus.o_busy !== 1'b1)
      $display("FAIL wd_fire: got to=%b busy=%b required %b 1", bus.o_timeout, bus.o_busy, TO_EN);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) step();
    bus.i_freeNext = 4'h4;
    step();
    bus.i_freeNext = 4'h0;
    total_cnt++;
    if (bus.o_free !== 1'b1 || bus.o_timeout !== TO_EN)
      $display("FAIL wd_late_free: got free=%b to=%b required 1 %b", bus.o_free, bus.o_timeout, TO_EN);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if (bus.o_timeout !== TO_EN || bus.o_busy !== 1'b0)
      $display("FAIL wd_sticky: got to=%b busy=%b required %b 0", bus.o_timeout, bus.o_busy, TO_EN);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_basic();
    test_frees_together();
    test_stray_dup_frees();
    test_overrun();
    test_reset_mid_wait();
    test_watchdog();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
